ex_muldiv_seq: RTL

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/ex_muldiv_seq_pkg.sv | 63 ++++++
 rtl/ex_muldiv_step.sv | 39 +++
 rtl/ex_muldiv_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared core package for the EX-stage sequential multiply/divide unit:
// RV64M funct3 encodings, FSM state enum, operation kinds and the request
// struct passed from operand decode to the iterating datapath.
`ifndef RNG_64
`define RNG_64 63:0
`endif

package ex_muldiv_seq_pkg;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } muldiv_funct3_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } muldiv_state_e;

   // Which half / which output of the iterated datapath is returned.
   typedef enum logic [1:0] {
      K_MUL_LO  = 2'd0,
      K_MUL_HI  = 2'd1,
      K_DIV_QUO = 2'd2,
      K_DIV_REM = 2'd3
   } muldiv_kind_e;

   // Decoded operation as captured at accept. opa is the multiplicand or
   // divisor magnitude; opb is the operand scanned one bit per iteration
   // (multiplier or dividend magnitude). neg requests negation at finish.
   typedef struct packed {
      muldiv_kind_e   kind;
      logic           word;
      logic           neg;
      logic [`RNG_64] opa;
      logic [`RNG_64] opb;
   } muldiv_req_t;

   localparam logic [5:0]     CNT_LAST_64 = 6'd63;
   localparam logic [5:0]     CNT_LAST_32 = 6'd31;
   localparam logic [`RNG_64] MOST_NEG_64 = 64'h8000_0000_0000_0000;
   localparam logic [`RNG_64] MOST_NEG_W  = 64'hFFFF_FFFF_8000_0000;
   localparam logic [`RNG_64] ALL_ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;

   // W-variant results are the low word sign-extended to 64 bits.
   function automatic logic [`RNG_64] wrap_result(input logic word, input logic [`RNG_64] val);
      logic [`RNG_64] res;
      if (word) begin
         res = {{32{val[31]}}, val[31:0]};
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Multiply: MSB-first shift-add, acc = 2*acc + (bit ? opnd : 0).
// Divide: restoring shift-subtract; acc[127:64] holds the partial remainder,
// acc[63:0] collects quotient bits from the LSB end.
module ex_muldiv_step
   import ex_muldiv_seq_pkg::*;
(
   input  logic           is_div,
   input  logic [127:0]   acc,
   input  logic [`RNG_64] opnd,
   input  logic           bit_in,
   output logic [127:0]   acc_next
);

   logic [64:0] rem_shift_s;
   logic [65:0] rem_diff_s;

   // Compute the next accumulator value for a single iteration.
   always_comb begin
      acc_next    = 128'd0;
      rem_shift_s = {acc[127:64], bit_in};
      rem_diff_s  = {1'b0, rem_shift_s} - {2'b00, opnd};
      if (is_div) begin
         // Borrow clear means the shifted remainder covers the divisor.
         if (!rem_diff_s[65]) begin
            acc_next = {rem_diff_s[63:0], acc[62:0], 1'b1};
         end else begin
            acc_next = {rem_shift_s[63:0], acc[62:0], 1'b0};
         end
      end else begin
         if (bit_in) begin
            acc_next = {acc[126:0], 1'b0} + {64'd0, opnd};
         end else begin
            acc_next = {acc[126:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Sequential RV64M multiply/divide unit for the EX stage. Operands are
// reduced to magnitudes at accept, iterated one bit per cycle (64 or 32
// iterations), and the sign is fixed up when the last iteration lands in
// the result register. Divide-by-zero and signed overflow skip iteration.
module ex_muldiv_seq
   import ex_muldiv_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_valid,
   input  logic [2:0]     i_funct3,
   input  logic           i_word,
   input  logic [`RNG_64] i_rs1,
   input  logic [`RNG_64] i_rs2,
   input  logic [4:0]     i_rd,
   input  logic           i_flush,
   input  logic           i_mem_ready,
   output logic           o_ready,
   output logic           o_valid,
   output logic [`RNG_64] o_result,
   output logic [4:0]     o_rd,
   output logic           o_busy
);

   muldiv_state_e  state_r, state_nxt_s;
   muldiv_req_t    req_s, req_r;
   muldiv_funct3_e f3_s;
   muldiv_kind_e   kind_base_s, kind_s;

   logic           is_div_s, sg1_base_s, sg2_base_s, sg1_s, sg2_s;
   logic           neg1_s, neg2_s, div_zero_s, ovf_s, bypass_s;
   logic [`RNG_64] x1_s, x2_s, m1_s, m2_s, most_neg_s, byp_raw_s, byp_res_s;
   logic [`RNG_64] quo_s, rem_s, raw_s, fin_res_s;
   logic [127:0]   prod_s, acc_r, acc_nxt_s;
   logic [5:0]     cnt_r;
   logic [4:0]     rd_r, rd_out_r;
   logic [`RNG_64] result_r;
   logic           ready_r, valid_r, busy_r;
   logic           accept_s, finish_s;
   logic           step_is_div_s, step_bit_s;

   // Classify the offered funct3 into kind and operand signedness.
   always_comb begin
      f3_s        = muldiv_funct3_e'(i_funct3);
      kind_base_s = K_MUL_LO;
      sg1_base_s  = 1'b0;
      sg2_base_s  = 1'b0;
      is_div_s    = 1'b0;
      case (f3_s)
         F3_MUL:    kind_base_s = K_MUL_LO;
         F3_MULH:   begin kind_base_s = K_MUL_HI; sg1_base_s = 1'b1; sg2_base_s = 1'b1; end
         F3_MULHSU: begin kind_base_s = K_MUL_HI; sg1_base_s = 1'b1; end
         F3_MULHU:  kind_base_s = K_MUL_HI;
         F3_DIV:    begin kind_base_s = K_DIV_QUO; is_div_s = 1'b1; sg1_base_s = 1'b1; sg2_base_s = 1'b1; end
         F3_DIVU:   begin kind_base_s = K_DIV_QUO; is_div_s = 1'b1; end
         F3_REM:    begin kind_base_s = K_DIV_REM; is_div_s = 1'b1; sg1_base_s = 1'b1; sg2_base_s = 1'b1; end
         F3_REMU:   begin kind_base_s = K_DIV_REM; is_div_s = 1'b1; end
         default:   kind_base_s = K_MUL_LO;
      endcase
   end

   // Apply the W override, extend operands, take magnitudes, build the request.
   always_comb begin
      // Every W multiply (including the unused MULH*W encodings) is MULW;
      // its low word does not depend on operand signedness.
      if (i_word && !is_div_s) begin
         kind_s = K_MUL_LO;
         sg1_s  = 1'b0;
         sg2_s  = 1'b0;
      end else begin
         kind_s = kind_base_s;
         sg1_s  = sg1_base_s;
         sg2_s  = sg2_base_s;
      end
      if (i_word) begin
         x1_s = sg1_s ? {{32{i_rs1[31]}}, i_rs1[31:0]} : {32'd0, i_rs1[31:0]};
         x2_s = sg2_s ? {{32{i_rs2[31]}}, i_rs2[31:0]} : {32'd0, i_rs2[31:0]};
      end else begin
         x1_s = i_rs1;
         x2_s = i_rs2;
      end
      neg1_s = sg1_s & x1_s[63];
      neg2_s = sg2_s & x2_s[63];
      m1_s   = neg1_s ? (64'd0 - x1_s) : x1_s;
      m2_s   = neg2_s ? (64'd0 - x2_s) : x2_s;

      req_s      = '0;
      req_s.kind = kind_s;
      req_s.word = i_word;
      if (is_div_s) begin
         req_s.opa = m2_s;
         req_s.opb = m1_s;
         req_s.neg = (kind_s == K_DIV_REM) ? neg1_s : (neg1_s ^ neg2_s);
      end else begin
         req_s.opa = m1_s;
         req_s.opb = m2_s;
         req_s.neg = (kind_s == K_MUL_HI) ? (neg1_s ^ neg2_s) : 1'b0;
      end
   end

   // Detect the cases answered without iterating and form their result.
   always_comb begin
      most_neg_s = i_word ? MOST_NEG_W : MOST_NEG_64;
      div_zero_s = is_div_s && (x2_s == 64'd0);
      ovf_s      = is_div_s && sg1_s && (x1_s == most_neg_s) && (x2_s == ALL_ONES_64);
      bypass_s   = div_zero_s || ovf_s;
      byp_raw_s  = 64'd0;
      if (div_zero_s) begin
         byp_raw_s = (kind_s == K_DIV_REM) ? x1_s : ALL_ONES_64;
      end else if (ovf_s) begin
         byp_raw_s = (kind_s == K_DIV_REM) ? 64'd0 : x1_s;
      end else begin
         byp_raw_s = 64'd0;
      end
      byp_res_s = wrap_result(i_word, byp_raw_s);
   end

   // Next-state logic; flush wins over accept and over MEM handshake.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (i_flush) begin
               state_nxt_s = S_IDLE;
            end else if (i_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = bypass_s ? S_DONE : S_BUSY;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_BUSY: begin
            if (i_flush) begin
               state_nxt_s = S_IDLE;
            end else if (cnt_r == 6'd0) begin
               finish_s    = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_BUSY;
            end
         end
         S_DONE: begin
            if (i_flush || i_mem_ready) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   assign step_is_div_s = (req_r.kind == K_DIV_QUO) || (req_r.kind == K_DIV_REM);
   assign step_bit_s    = req_r.opb[cnt_r];

   ex_muldiv_step u_step (
      .is_div   (step_is_div_s),
      .acc      (acc_r),
      .opnd     (req_r.opa),
      .bit_in   (step_bit_s),
      .acc_next (acc_nxt_s)
   );

   // Sign fix-up and selection of the final result from the last iteration.
   always_comb begin
      if (req_r.neg) begin
         prod_s = 128'd0 - acc_nxt_s;
         quo_s  = 64'd0 - acc_nxt_s[63:0];
         rem_s  = 64'd0 - acc_nxt_s[127:64];
      end else begin
         prod_s = acc_nxt_s;
         quo_s  = acc_nxt_s[63:0];
         rem_s  = acc_nxt_s[127:64];
      end
      case (req_r.kind)
         K_MUL_LO:  raw_s = prod_s[63:0];
         K_MUL_HI:  raw_s = prod_s[127:64];
         K_DIV_QUO: raw_s = quo_s;
         K_DIV_REM: raw_s = rem_s;
         default:   raw_s = 64'd0;
      endcase
      fin_res_s = wrap_result(req_r.word, raw_s);
   end

   // State register and registered status flags derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == S_IDLE);
         busy_r  <= (state_nxt_s != S_IDLE);
         valid_r <= (state_nxt_s == S_DONE);
      end
   end

   // Operand capture, iteration counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r <= '0;
         rd_r  <= 5'd0;
         cnt_r <= 6'd0;
         acc_r <= 128'd0;
      end else if (accept_s) begin
         req_r <= req_s;
         rd_r  <= i_rd;
         cnt_r <= i_word ? CNT_LAST_32 : CNT_LAST_64;
         acc_r <= 128'd0;
      end else if ((state_r == S_BUSY) && !i_flush) begin
         acc_r <= acc_nxt_s;
         cnt_r <= (cnt_r == 6'd0) ? 6'd0 : (cnt_r - 6'd1);
      end else if (i_flush) begin
         cnt_r <= 6'd0;
         acc_r <= 128'd0;
      end
   end

   // Result and tag registers: loaded on entry to DONE, held there, zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= 64'd0;
         rd_out_r <= 5'd0;
      end else if (accept_s && bypass_s) begin
         result_r <= byp_res_s;
         rd_out_r <= i_rd;
      end else if (finish_s) begin
         result_r <= fin_res_s;
         rd_out_r <= rd_r;
      end else if (state_nxt_s != S_DONE) begin
         result_r <= 64'd0;
         rd_out_r <= 5'd0;
      end
   end

   assign o_ready  = ready_r;
   assign o_valid  = valid_r;
   assign o_busy   = busy_r;
   assign o_result = result_r;
   assign o_rd     = rd_out_r;

endmodule
